// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the MEM-stage load/store sequencer: aligner width codes,
// response error codes, RV32I load/store funct3 values and the FSM state type.
package lsu_ctrl_pkg;

    localparam logic [1:0] DM_NONE  = 2'b00;
    localparam logic [1:0] DM_BYTE  = 2'b01;
    localparam logic [1:0] DM_HWORD = 2'b10;
    localparam logic [1:0] DM_WORD  = 2'b11;

    localparam logic [1:0] LSU_ERR_OK       = 2'b00;
    localparam logic [1:0] LSU_ERR_MISALIGN = 2'b01;
    localparam logic [1:0] LSU_ERR_RANGE    = 2'b10;
    localparam logic [1:0] LSU_ERR_FUNCT3   = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } lsu_state_e;

    // Illegal encoding outranks misalignment, which outranks the window check.
    function automatic logic [1:0] lsu_err_code(input logic illegal,
                                                input logic misaligned,
                                                input logic out_of_range);
        if (illegal)           return LSU_ERR_FUNCT3;
        else if (misaligned)   return LSU_ERR_MISALIGN;
        else if (out_of_range) return LSU_ERR_RANGE;
        else                   return LSU_ERR_OK;
    endfunction

endpackage

// File: rtl/lsu_ctrl_decode.sv
// Combinational request decode: funct3/type/address -> aligner width, sign control
// and the three error conditions.
module lsu_ctrl_decode
    import lsu_ctrl_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE = 32'h0010_0000,
    parameter int unsigned DMEM_SIZE = 32768
) (
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    output logic [1:0]  width,
    output logic        load_signed,
    output logic        illegal,
    output logic        misaligned,
    output logic        out_of_range
);

    logic [31:0] offset;

    always_comb begin
        case (funct3[1:0])
            2'b00:   width = DM_BYTE;
            2'b01:   width = DM_HWORD;
            2'b10:   width = DM_WORD;
            default: width = DM_NONE;
        endcase

        load_signed = is_load & ~funct3[2];

        if (is_load)
            illegal = !(funct3 == F3_LB || funct3 == F3_LH || funct3 == F3_LW ||
                        funct3 == F3_LBU || funct3 == F3_LHU);
        else
            illegal = is_store & !(funct3 == F3_SB || funct3 == F3_SH || funct3 == F3_SW);

        misaligned = ((width == DM_HWORD) && addr[0]) ||
                     ((width == DM_WORD) && (addr[1:0] != 2'b00));

        // Unsigned wrap makes addresses below the base land far out of range.
        offset       = addr - DMEM_BASE;
        out_of_range = (offset >= 32'(DMEM_SIZE));
    end

endmodule

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store sequencer: accepts one request from EX, drives the data
// aligner for the required cycles and returns data plus an error code to WB.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE    = 32'h0010_0000,
    parameter int unsigned DMEM_SIZE    = 32768,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic [31:0] al_addr,
    output logic [31:0] al_wdata,
    output logic [1:0]  al_write_status,
    output logic [1:0]  al_read_status,
    output logic        al_load_signed,
    input  logic [31:0] al_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_rd,
    output logic [1:0]  rsp_err,
    output logic        busy
);

    localparam logic [2:0] RD_LAT = 3'(READ_LATENCY);

    lsu_state_e  state_reg;
    logic [2:0]  cnt_reg;
    logic [4:0]  rd_reg;
    logic        is_load_reg;

    logic        is_load;
    logic        is_store;
    logic [1:0]  dec_width;
    logic        dec_signed;
    logic        dec_illegal;
    logic        dec_misaligned;
    logic        dec_out_of_range;
    logic [1:0]  dec_err;

    assign is_load  = req_load;
    assign is_store = req_store & ~req_load;

    lsu_ctrl_decode #(
        .DMEM_BASE (DMEM_BASE),
        .DMEM_SIZE (DMEM_SIZE)
    ) u_decode (
        .is_load      (is_load),
        .is_store     (is_store),
        .funct3       (req_funct3),
        .addr         (req_addr),
        .width        (dec_width),
        .load_signed  (dec_signed),
        .illegal      (dec_illegal),
        .misaligned   (dec_misaligned),
        .out_of_range (dec_out_of_range)
    );

    assign dec_err   = lsu_err_code(dec_illegal, dec_misaligned, dec_out_of_range);
    assign req_ready = (state_reg == ST_IDLE);
    assign busy      = (state_reg != ST_IDLE);

    // The al_* registers double as the request latches: they are loaded on accept
    // and cleared on leaving ACCESS, so the aligner sees DM_NONE everywhere else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= 3'd0;
            rd_reg          <= 5'd0;
            is_load_reg     <= 1'b0;
            al_addr         <= 32'd0;
            al_wdata        <= 32'd0;
            al_write_status <= DM_NONE;
            al_read_status  <= DM_NONE;
            al_load_signed  <= 1'b0;
            rsp_valid       <= 1'b0;
            rsp_data        <= 32'd0;
            rsp_rd          <= 5'd0;
            rsp_err         <= LSU_ERR_OK;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid && (is_load || is_store)) begin
                        if (dec_err != LSU_ERR_OK) begin
                            state_reg <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= dec_err;
                            rsp_data  <= 32'd0;
                            rsp_rd    <= is_load ? req_rd : 5'd0;
                        end else begin
                            state_reg       <= ST_ACCESS;
                            cnt_reg         <= 3'd0;
                            rd_reg          <= req_rd;
                            is_load_reg     <= is_load;
                            al_addr         <= req_addr;
                            al_wdata        <= req_wdata;
                            al_load_signed  <= dec_signed;
                            al_write_status <= is_store ? dec_width : DM_NONE;
                            al_read_status  <= is_load  ? dec_width : DM_NONE;
                        end
                    end
                end

                ST_ACCESS: begin
                    if (!is_load_reg || cnt_reg == RD_LAT) begin
                        state_reg       <= ST_RESP;
                        rsp_valid       <= 1'b1;
                        rsp_err         <= LSU_ERR_OK;
                        rsp_data        <= is_load_reg ? al_rdata : 32'd0;
                        rsp_rd          <= is_load_reg ? rd_reg : 5'd0;
                        al_addr         <= 32'd0;
                        al_wdata        <= 32'd0;
                        al_load_signed  <= 1'b0;
                        al_write_status <= DM_NONE;
                        al_read_status  <= DM_NONE;
                    end else begin
                        cnt_reg <= cnt_reg + 3'd1;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        state_reg <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        rsp_data  <= 32'd0;
                        rsp_rd    <= 5'd0;
                        rsp_err   <= LSU_ERR_OK;
                    end
                end

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
